// File: rtl/sevenseg_pkg.sv
// Shared seven-segment types, blank constant and hex decoder.
// Segment order is {a,b,c,d,e,f,g} = seg[6:0], active-high.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;

  function automatic seg_t hex_decode(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1110011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      4'hF:    seg = 7'b1000111;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_prescaler.sv
// Dwell prescaler: counts 0..CLK_DIV-1 and flags the last count with a
// one-cycle tick. CLK_DIV must be at least 2.
module sevenseg_prescaler
  import sevenseg_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count and terminal-count tick.
  always_comb begin
    tick = (cnt_q == CNT_W'(CLK_DIV - 1));
    if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment scanner with a double-buffered display.
// Define SEVENSEG_LZB_EN to blank leading zeros (digit 0 always lit).
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int CLK_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     dp_in,
  output logic [6:0]             segments,
  output logic                   dp,
  output logic [NDIGITS-1:0]     anode,
  output logic                   frame,
  output logic                   pending
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic                 tick_s;
  logic                 wrap_s;
  logic [3:0]           cur_nib_s;
  logic                 cur_dp_s;
  logic                 blank_s;

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*NDIGITS-1:0] disp_data_q, disp_data_d;
  logic [NDIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NDIGITS-1:0] pend_data_q, pend_data_d;
  logic [NDIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                 pending_q, pending_d;
  seg_t                 segments_q, segments_d;
  logic                 dp_q, dp_d;
  logic [NDIGITS-1:0]   anode_q, anode_d;
  logic                 frame_q, frame_d;

  sevenseg_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  // Scan index, buffer hand-off and pending flag.
  always_comb begin
    wrap_s      = tick_s && (idx_q == IDX_W'(NDIGITS - 1));
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pending_d   = pending_q;

    if (wrap_s) begin
      idx_d = '0;
    end else if (tick_s) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end

    // A load landing on the wrap bypasses the pending buffer entirely.
    if (load && wrap_s) begin
      disp_data_d = data;
      disp_dp_d   = dp_in;
      pending_d   = 1'b0;
    end else if (load) begin
      pend_data_d = data;
      pend_dp_d   = dp_in;
      pending_d   = 1'b1;
    end else if (wrap_s && pending_q) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pending_d   = 1'b0;
    end else begin
      pending_d   = pending_q;
    end
  end

  // Output values for the digit that will be enabled after this edge.
  always_comb begin
    cur_nib_s = 4'h0;
    cur_dp_s  = 1'b0;
    anode_d   = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      anode_d[i] = (idx_d == IDX_W'(i));
      cur_nib_s  = cur_nib_s | ({4{anode_d[i]}} & disp_data_d[4*i +: 4]);
      cur_dp_s   = cur_dp_s | (anode_d[i] & disp_dp_d[i]);
    end
`ifdef SEVENSEG_LZB_EN
    blank_s = 1'b0;
    begin : lzb
      logic zero_run_s;
      zero_run_s = 1'b1;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
        zero_run_s = zero_run_s & (disp_data_d[4*i +: 4] == 4'h0);
        blank_s    = blank_s | (anode_d[i] & zero_run_s & (i > 0));
      end
    end
`else
    blank_s = 1'b0;
`endif
    segments_d = blank_s ? SEG_BLANK : hex_decode(cur_nib_s);
    dp_d       = cur_dp_s;
    frame_d    = wrap_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pending_q   <= 1'b0;
      segments_q  <= SEG_BLANK;
      dp_q        <= 1'b0;
      anode_q     <= '0;
      frame_q     <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pending_q   <= pending_d;
      segments_q  <= segments_d;
      dp_q        <= dp_d;
      anode_q     <= anode_d;
      frame_q     <= frame_d;
    end
  end

  assign segments = segments_q;
  assign dp       = dp_q;
  assign anode    = anode_q;
  assign frame    = frame_q;
  assign pending  = pending_q;

endmodule
